mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port data memory (Memory_Data) between the pipeline MEM stage (port P) and a
//  debug/loader port (port D). P has fixed priority; D is protected from starvation and may lock
//  the memory for bursts. Sits between the EX/MEM register outputs and Memory_Data; drives P stall.
// PARAMETERS
//  ADDR_W        16  address width (matches ALU result)
//  DATA_W        16  data width
//  STARVE_LIMIT  4   consecutive cycles D may wait before it preempts P (>=1)
//  LOCK_MAX      8   max consecutive cycles D may hold the lock (>=1)
// PORTS
//  clk       in   1       system clock, all state on rising edge
//  reset     in   1       asynchronous, active-low reset
//  p_read    in   1       P read request (MemRead)
//  p_write   in   1       P write request (MemWrite); p_read&p_write is treated as write
//  p_addr    in   ADDR_W  P address
//  p_wdata   in   DATA_W  P write data
//  p_stall   out  1       P request not served this cycle; P holds its request
//  p_rdata   out  DATA_W  read data for P
//  p_rvalid  out  1       p_rdata valid (1 cycle after granted P read)
//  d_req     in   1       D access request
//  d_we      in   1       D write (1) / read (0)
//  d_lock    in   1       D requests to keep ownership after this grant
//  d_addr    in   ADDR_W  D address
//  d_wdata   in   DATA_W  D write data
//  d_gnt     out  1       D access performed this cycle
//  d_rdata   out  DATA_W  read data for D
//  d_rvalid  out  1       d_rdata valid (1 cycle after granted D read)
//  mem_addr  out  ADDR_W  to Memory_Data.addr
//  mem_data  out  DATA_W  to Memory_Data.data
//  mem_we    out  1       to Memory_Data.we
//  mem_q     in   DATA_W  from Memory_Data.q (registered, valid cycle after address)
// BEHAVIOUR
//  - Reset (reset=0): state=ARB, wait_cnt=0, lock_cnt=0, rd_owner=NONE; p_rvalid=d_rvalid=0;
//    mem_we=0, p_stall=0, d_gnt=0 forced while reset low. rdata outputs = mem_q passthrough.
//  - One access per cycle; grant decision combinational, memory samples on the next rising edge.
//  - FSM states: ARB, DLOCK.
//    ARB: p_req=p_read|p_write. If d_req & (!p_req | wait_cnt==STARVE_LIMIT) -> grant D,
//      else if p_req -> grant P, else idle (mem_we=0, mem_addr=p_addr).
//      wait_cnt: +1 each cycle d_req & !d_gnt (saturates at STARVE_LIMIT); cleared on d_gnt or !d_req.
//      D granted with d_lock=1 -> DLOCK, lock_cnt=1.
//    DLOCK: D owns memory; d_gnt=d_req; any p_req gets p_stall=1. lock_cnt +1 per cycle.
//      Exit to ARB when d_lock=0 or lock_cnt==LOCK_MAX; exit cycle is still D-owned;
//      wait_cnt=0 on exit. Re-entry needs a fresh grant from ARB (P gets >=1 cycle if requesting).
//  - p_stall = p_req & !(P granted). Never both d_gnt and P granted in one cycle.
//  - mem_we = granted write; mem_addr/mem_data muxed from granted port.
//  - Read return: rd_owner registered on granted read (P or D), NONE otherwise; p_rvalid/d_rvalid
//    asserted the following cycle per rd_owner. Writes never raise rvalid.
//  - Back-to-back reads from alternating owners each return correctly tagged, 1 cycle latency.
//  - Reset mid-DLOCK or with read in flight: state->ARB, in-flight rvalid dropped.
//  - No address range checks; full ADDR_W passed through unchanged.
// STRUCTURE
//  - Shared package misc_mem_pkg: arb_state_t {ARB, DLOCK}, owner_t {NONE, P, D},
//    default STARVE_LIMIT/LOCK_MAX constants.
//  - Single flat module; no sub-module (grant mux + FSM + two counters + owner register).
//  - Instantiated alongside Memory_Data in the memory stage; EX/MEM register held by p_stall.
// TESTING
//  - P read 0x0010 only -> p_stall=0, mem_addr=0x0010, p_rvalid=1 next cycle with mem_q, d_rvalid=0.
//  - P idle, D write 0x0100<=0xBEEF -> d_gnt=1 same cycle, mem_we=1, mem_data=0xBEEF; readback ok.
//  - P requests every cycle, D requests continuously -> D granted on 5th cycle (STARVE_LIMIT=4),
//    p_stall=1 exactly that cycle, wait_cnt back to 0.
//  - D lock burst with d_lock held 20 cycles, P requesting -> D owns 8 cycles, then P granted
//    >=1 cycle before D regrants; p_stall=1 for all 8 locked cycles.
//  - Alternating P read 0x0002 / D read 0x0003 -> rvalids alternate, data tags correct.
//  - reset low during DLOCK with D read in flight -> all outputs 0 next cycle, state ARB, no rvalid.

Source files
------------

// File: rtl/misc_mem_pkg.sv
// Shared types and default limits for the data-memory port arbiter.
package misc_mem_pkg;

    typedef enum logic {
        ARB,
        DLOCK
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE,
        P,
        D
    } owner_t;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int LOCK_MAX_DEF     = 8;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage (P, fixed priority)
// and the debug/loader port (D, starvation-protected, may lock the memory for bursts).
module mem_port_arbiter
    import misc_mem_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int LOCK_MAX     = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_read,
    input  logic              p_write,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_stall,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam int LOCK_W = $clog2(LOCK_MAX + 2);

    arb_state_t        state_q, state_d;
    owner_t            rdOwner_q, rdOwner_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic [LOCK_W-1:0] lockCnt_q, lockCnt_d;
    logic              pReq;
    logic              pGrant;
    logic              dGrant;

    assign pReq = p_read | p_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ARB;
            rdOwner_q <= NONE;
            waitCnt_q <= '0;
            lockCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rdOwner_q <= rdOwner_d;
            waitCnt_q <= waitCnt_d;
            lockCnt_q <= lockCnt_d;
        end
    end

    // DLOCK lasts LOCK_MAX cycles after the granting ARB cycle; its last cycle is still D-owned.
    always_comb begin
        state_d   = state_q;
        lockCnt_d = lockCnt_q;
        waitCnt_d = waitCnt_q;
        rdOwner_d = NONE;
        pGrant    = 1'b0;
        dGrant    = 1'b0;

        case (state_q)
            ARB: begin
                if (d_req && (!pReq || waitCnt_q == WAIT_W'(STARVE_LIMIT))) begin
                    dGrant = 1'b1;
                end else if (pReq) begin
                    pGrant = 1'b1;
                end
                if (dGrant && d_lock) begin
                    state_d   = DLOCK;
                    lockCnt_d = LOCK_W'(1);
                end
            end
            DLOCK: begin
                dGrant    = d_req;
                lockCnt_d = lockCnt_q + LOCK_W'(1);
                if (!d_lock || lockCnt_q == LOCK_W'(LOCK_MAX)) begin
                    state_d   = ARB;
                    lockCnt_d = '0;
                end
            end
            default: begin
                state_d   = ARB;
                lockCnt_d = '0;
            end
        endcase

        if (!reset) begin
            pGrant = 1'b0;
            dGrant = 1'b0;
        end

        if (dGrant || !d_req) begin
            waitCnt_d = '0;
        end else if (waitCnt_q != WAIT_W'(STARVE_LIMIT)) begin
            waitCnt_d = waitCnt_q + WAIT_W'(1);
        end

        // A simultaneous read+write from P counts as a write, so it never tags a read return.
        if (pGrant && !p_write) begin
            rdOwner_d = P;
        end else if (dGrant && !d_we) begin
            rdOwner_d = D;
        end
    end

    assign d_gnt    = dGrant;
    assign p_stall  = reset & pReq & ~pGrant;
    assign mem_we   = dGrant ? d_we : (pGrant & p_write);
    assign mem_addr = dGrant ? d_addr : p_addr;
    assign mem_data = dGrant ? d_wdata : p_wdata;
    assign p_rdata  = mem_q;
    assign d_rdata  = mem_q;
    assign p_rvalid = (rdOwner_q == P);
    assign d_rvalid = (rdOwner_q == D);

endmodule
